input_route_unit: RTL and testbench
===================================

INPUT_ROUTE_UNIT -- requirements
Module: input_route_unit

Interface
REQ-001 SHALL have parameter ValidBitPos, default 81, bit position of the flit valid bit; FlitWidth = ValidBitPos+1.
REQ-002 SHALL have parameter lg_numprocs, default 3, child-field width; FlitChildWidth = FlitWidth+lg_numprocs (85 by default).
REQ-003 SHALL have parameter COORD_W, default 2, per-dimension torus coordinate width (torus of 2^COORD_W nodes per dimension).
REQ-004 SHALL have parameter DST_LSB, default 0, LSB of the packed flit fields dst_x, dst_y, dst_z (COORD_W bits each, x lowest).
REQ-005 SHALL have parameter LG_DEPTH, default 2, log2 of FIFO depth.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 cur_x, cur_y, cur_z  input  COORD_W each  local node coordinates; static after reset.
REQ-009 in  input  FlitChildWidth  flit from link.
REQ-010 in_valid  input  1  upstream flit present.
REQ-011 in_avail  output  1  FIFO can accept a flit this cycle.
REQ-012 out  output  FlitChildWidth  head flit toward switch.
REQ-013 route_out  output  3  direction of head flit (0 local, 1-6 XPOS..ZNEG).
REQ-014 out_valid  output  1  head flit present and route_out nonzero.
REQ-015 out_ready  input  1  switch accepts head (driven by switch in_avail for this port).
REQ-016 eject_valid  output  1  head flit present and route_out = 0.
REQ-017 eject_ready  input  1  local sink accepts head.
REQ-018 overflow  output  1  sticky: push attempted while full.

Function
REQ-019 Push when in_valid && in_avail; in_avail = !full, combinational from the registered count.
REQ-020 Pop when (out_valid && out_ready) || (eject_valid && eject_ready); exactly one head leaves per pop.
REQ-021 Latency: a flit pushed at cycle N SHALL be visible on out at N+1 at the earliest; no combinational path from in to out.
REQ-022 Simultaneous push and pop SHALL keep count unchanged; when full, pop and push in the same cycle are not allowed (in_avail low).
REQ-023 in_valid while full SHALL drop the flit, leave FIFO untouched and set overflow until reset.
REQ-024 Pointers wrap modulo 2^LG_DEPTH; count is LG_DEPTH+1 bits; full at count = 2^LG_DEPTH, empty at 0.
REQ-025 Route: dimension order X, then Y, then Z; d = (dst - cur) mod 2^COORD_W for the first dimension with d != 0.
REQ-026 Route direction: d <= 2^(COORD_W-1) gives POS (1/2/3), else NEG (4/5/6); the half-way tie resolves to POS.
REQ-027 All three dimensions with d = 0 SHALL give route 0 (eject).
REQ-028 route_out SHALL be computed at enqueue and stored with the flit, so that route_out is registered.
REQ-029 Empty FIFO: out_valid = eject_valid = 0, route_out = 0, out = 0.

Reset
REQ-030 On rst low: pointers, count, overflow = 0; out_valid = eject_valid = 0; in_avail = 1 immediately.
REQ-031 Reset mid-operation SHALL discard all buffered flits; no partial flit SHALL emerge after release.

Configuration
REQ-032 With macro INPUT_ROUTE_UNIT_OCCUPANCY_EN defined: add output occupancy [LG_DEPTH:0] equal to the registered count, 0 in reset.
REQ-033 Without INPUT_ROUTE_UNIT_OCCUPANCY_EN: the port is absent; all other behaviour is identical.

Structure
REQ-034 DIR_XPOS..DIR_ZNEG (1-6), DIR_LOCAL (0), ROUTE_LEN = 3 SHALL live in the shared noc package, also used by switch.
REQ-035 Route computation SHALL be a separate combinational sub-module route_calc (inputs dst and cur; output 3-bit route); the FIFO stays inline.

Verification
REQ-036 cur = (0,0,0), push dst (1,0,0) -> next cycle out_valid = 1, route_out = 1; out_ready = 1 pops it.
REQ-037 cur = (0,0,0): dst (3,0,0) -> route 4; dst (0,2,0) -> route 2 (tie); dst (0,0,0) -> eject_valid = 1, out_valid = 0.
REQ-038 out_ready = 0, push 4 flits -> in_avail = 0; 5th in_valid -> overflow = 1, and 4 flits drain in order.
REQ-039 Full FIFO, out_ready = 1 with in_valid held -> one pop then one push per cycle; order preserved and count stays at 3-4.
REQ-040 rst low with 3 flits buffered -> out_valid = 0, in_avail = 1, overflow = 0 asynchronously; no stale flit emerges after release.
REQ-041 With INPUT_ROUTE_UNIT_OCCUPANCY_EN: occupancy tracks 0 -> 1 -> 2 -> 1 over push, push, pop.

Source files
------------

// File: rtl/input_route_unit_pkg.sv
// Shared NoC definitions: the route direction encoding used by the input route unit and the switch.
package input_route_unit_pkg;

    localparam int unsigned ROUTE_LEN = 3;

    typedef enum logic [ROUTE_LEN-1:0] {
        DIR_LOCAL = 3'd0,
        DIR_XPOS  = 3'd1,
        DIR_YPOS  = 3'd2,
        DIR_ZPOS  = 3'd3,
        DIR_XNEG  = 3'd4,
        DIR_YNEG  = 3'd5,
        DIR_ZNEG  = 3'd6
    } dir_e;

endpackage

// File: rtl/input_route_unit_route_calc.sv
// Dimension-order (X, Y, Z) torus route computation; shortest direction, half-way tie goes positive.
module route_calc
    import input_route_unit_pkg::*;
#(
    parameter int unsigned COORD_W = 2
) (
    input  logic [3*COORD_W-1:0] dst,
    input  logic [3*COORD_W-1:0] cur,
    output logic [ROUTE_LEN-1:0] route
);

    localparam logic [COORD_W-1:0] Half = COORD_W'(1) << (COORD_W - 1);

    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [COORD_W-1:0] dz;

    // Modular distance along each ring, wrapping naturally in COORD_W bits.
    assign dx = dst[0         +: COORD_W] - cur[0         +: COORD_W];
    assign dy = dst[COORD_W   +: COORD_W] - cur[COORD_W   +: COORD_W];
    assign dz = dst[2*COORD_W +: COORD_W] - cur[2*COORD_W +: COORD_W];

    always_comb begin
        route = DIR_LOCAL;
        if (dx != '0) begin
            route = (dx <= Half) ? DIR_XPOS : DIR_XNEG;
        end else if (dy != '0) begin
            route = (dy <= Half) ? DIR_YPOS : DIR_YNEG;
        end else if (dz != '0) begin
            route = (dz <= Half) ? DIR_ZPOS : DIR_ZNEG;
        end
    end

endmodule

// File: rtl/input_route_unit.sv
// Link input buffer: FIFO of flits tagged at enqueue with their output direction.
// Optional occupancy port enabled by defining INPUT_ROUTE_UNIT_OCCUPANCY_EN.
module input_route_unit
    import input_route_unit_pkg::*;
#(
    parameter  int unsigned ValidBitPos    = 81,
    parameter  int unsigned lg_numprocs    = 3,
    parameter  int unsigned COORD_W        = 2,
    parameter  int unsigned DST_LSB        = 0,
    parameter  int unsigned LG_DEPTH       = 2,
    localparam int unsigned FlitWidth      = ValidBitPos + 1,
    localparam int unsigned FlitChildWidth = FlitWidth + lg_numprocs
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [COORD_W-1:0]        cur_x,
    input  logic [COORD_W-1:0]        cur_y,
    input  logic [COORD_W-1:0]        cur_z,
    input  logic [FlitChildWidth-1:0] in,
    input  logic                      in_valid,
    output logic                      in_avail,
    output logic [FlitChildWidth-1:0] out,
    output logic [ROUTE_LEN-1:0]      route_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      eject_valid,
    input  logic                      eject_ready,
`ifdef INPUT_ROUTE_UNIT_OCCUPANCY_EN
    output logic [LG_DEPTH:0]         occupancy,
`endif
    output logic                      overflow
);

    localparam int unsigned Depth = 1 << LG_DEPTH;

    logic [FlitChildWidth-1:0] flit_mem  [Depth];
    logic [ROUTE_LEN-1:0]      route_mem [Depth];

    logic [LG_DEPTH-1:0] wr_ptr;
    logic [LG_DEPTH-1:0] rd_ptr;
    logic [LG_DEPTH:0]   count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [ROUTE_LEN-1:0] in_route;
    logic [ROUTE_LEN-1:0] head_route;

    route_calc #(
        .COORD_W (COORD_W)
    ) u_route_calc (
        .dst   (in[DST_LSB +: 3*COORD_W]),
        .cur   ({cur_z, cur_y, cur_x}),
        .route (in_route)
    );

    assign full  = (count == (LG_DEPTH+1)'(Depth));
    assign empty = (count == '0);
    assign push  = in_valid && !full;
    assign pop   = (out_valid && out_ready) || (eject_valid && eject_ready);

    // Head view is forced to zero when empty so nothing stale is ever presented.
    assign head_route  = empty ? ROUTE_LEN'(DIR_LOCAL) : route_mem[rd_ptr];
    assign out         = empty ? '0 : flit_mem[rd_ptr];
    assign route_out   = head_route;
    assign out_valid   = !empty && (head_route != ROUTE_LEN'(DIR_LOCAL));
    assign eject_valid = !empty && (head_route == ROUTE_LEN'(DIR_LOCAL));
    assign in_avail    = !full;

`ifdef INPUT_ROUTE_UNIT_OCCUPANCY_EN
    assign occupancy = count;
`endif

    // Storage needs no reset: validity is carried entirely by count.
    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[wr_ptr]  <= in;
            route_mem[wr_ptr] <= in_route;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + LG_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + LG_DEPTH'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (LG_DEPTH+1)'(1);
                2'b01:   count <= count - (LG_DEPTH+1)'(1);
                default: count <= count;
            endcase
            if (in_valid && full) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_input_route_unit.sv
// Bench for input_route_unit: directed and random traffic against a queue-based reference model.
module tb_input_route_unit;

    localparam int unsigned FW    = 85;
    localparam int unsigned RING  = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    cur_x, cur_y, cur_z;
    logic [FW-1:0] in_flit;
    logic          in_valid;
    logic          in_avail;
    logic [FW-1:0] out_flit;
    logic [2:0]    route_out;
    logic          out_valid;
    logic          out_ready;
    logic          eject_valid;
    logic          eject_ready;
    logic          overflow;
`ifdef INPUT_ROUTE_UNIT_OCCUPANCY_EN
    logic [2:0]    occupancy;
`endif

    logic [FW-1:0] q[$];
    logic          ovf;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    input_route_unit dut (
        .clk         (clk),
        .rst         (rst),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .cur_z       (cur_z),
        .in          (in_flit),
        .in_valid    (in_valid),
        .in_avail    (in_avail),
        .out         (out_flit),
        .route_out   (route_out),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .eject_valid (eject_valid),
        .eject_ready (eject_ready),
`ifdef INPUT_ROUTE_UNIT_OCCUPANCY_EN
        .occupancy   (occupancy),
`endif
        .overflow    (overflow)
    );

    task automatic chk1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, got, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk(input int x, input int y, input int z);
        logic [FW-1:0] f;
        f      = FW'({$urandom(), $urandom(), $urandom()});
        f[1:0] = 2'(x);
        f[3:2] = 2'(y);
        f[5:4] = 2'(z);
        return f;
    endfunction

    function automatic logic [FW-1:0] mk_rand();
        return mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endfunction

    // Shortest-way torus direction, first non-zero dimension in X, Y, Z order.
    function automatic logic [2:0] ref_route(input logic [FW-1:0] f);
        int c[3];
        int d;
        c[0] = int'(cur_x);
        c[1] = int'(cur_y);
        c[2] = int'(cur_z);
        for (int k = 0; k < 3; k++) begin
            d = (int'(f[2*k +: 2]) - c[k] + int'(RING)) % int'(RING);
            if (d != 0) return (d <= int'(RING) / 2) ? 3'(k + 1) : 3'(k + 4);
        end
        return 3'd0;
    endfunction

    // One clock: drive, compare outputs against the model, advance model at the edge.
    task automatic cycle(input logic iv, input logic [FW-1:0] f, input logic ordy, input logic erdy);
        logic       hv;
        logic [2:0] hr;
        logic       do_push;
        logic       do_pop;
        in_valid    = iv;
        in_flit     = f;
        out_ready   = ordy;
        eject_ready = erdy;
        #1;
        hv = (q.size() > 0);
        hr = hv ? ref_route(q[0]) : 3'd0;
        chk1("in_avail", in_avail, q.size() < DEPTH);
        chk1("out_valid", out_valid, hv && (hr != 3'd0));
        chk1("eject_valid", eject_valid, hv && (hr == 3'd0));
        chkw("route_out", FW'(route_out), FW'(hr));
        chkw("out", out_flit, hv ? q[0] : '0);
        chk1("overflow", overflow, ovf);
`ifdef INPUT_ROUTE_UNIT_OCCUPANCY_EN
        chkw("occupancy", FW'(occupancy), FW'(q.size()));
`endif
        do_push = iv && (q.size() < DEPTH);
        do_pop  = hv && ((hr != 3'd0) ? ordy : erdy);
        @(posedge clk);
        #1;
        if (iv && (q.size() >= DEPTH)) ovf = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(f);
    endtask

    initial begin
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_flit     = '0;
        out_ready   = 1'b0;
        eject_ready = 1'b0;
        cur_x       = 2'd0;
        cur_y       = 2'd0;
        cur_z       = 2'd0;
        ovf         = 1'b0;
        #1;
        chk1("rst_in_avail", in_avail, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_eject_valid", eject_valid, 1'b0);
        chk1("rst_overflow", overflow, 1'b0);
        chkw("rst_route", FW'(route_out), '0);
        chkw("rst_out", out_flit, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single X+ hop, visible the cycle after the push, popped by the switch.
        cycle(1'b1, mk(1, 0, 0), 1'b0, 1'b0);
        chk1("xpos_valid", out_valid, 1'b1);
        chkw("xpos_route", FW'(route_out), FW'(3'd1));
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk1("xpos_popped", out_valid, 1'b0);

        // Negative wrap, half-way tie, and local eject.
        cycle(1'b1, mk(3, 0, 0), 1'b0, 1'b0);
        chkw("xneg_route", FW'(route_out), FW'(3'd4));
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, mk(0, 2, 0), 1'b0, 1'b0);
        chkw("ytie_route", FW'(route_out), FW'(3'd2));
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b1, mk(0, 0, 0), 1'b0, 1'b0);
        chk1("eject_valid_local", eject_valid, 1'b1);
        chk1("eject_out_valid", out_valid, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Fill, overflow on a fifth push, drain in order.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk_rand(), 1'b0, 1'b0);
        chk1("full_in_avail", in_avail, 1'b0);
        cycle(1'b1, mk_rand(), 1'b0, 1'b0);
        chk1("overflow_set", overflow, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        chk1("drained_in_avail", in_avail, 1'b1);

        // Full FIFO with a continuous stream in and out.
        for (int i = 0; i < 4; i++) cycle(1'b1, mk(1, $urandom_range(0, 3), 0), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, mk(1, $urandom_range(0, 3), 0), 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Asynchronous reset with three flits buffered.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(2, 1, 0), 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_eject_valid", eject_valid, 1'b0);
        chk1("arst_in_avail", in_avail, 1'b1);
        chk1("arst_overflow", overflow, 1'b0);
        q.delete();
        ovf   = 1'b0;
        in_valid = 1'b0;
        cur_x = 2'($urandom_range(0, 3));
        cur_y = 2'($urandom_range(0, 3));
        cur_z = 2'($urandom_range(0, 3));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 99) < 55), mk_rand(),
                  1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 60));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
